// File: rtl/stm_sequencer_if.sv
// Data-memory write port of the store-multiple sequencer.
// The sequencer drives it through the master modport; the memory answers through the slave modport.
interface stm_sequencer_if;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_ready;

  modport master (output mem_we, output mem_addr, output mem_wd, input mem_ready);
  modport slave  (input mem_we, input mem_addr, input mem_wd, output mem_ready);
endinterface

// File: rtl/stm_sequencer.sv
// Store-multiple sequencer: walks a register list and issues one memory word write per selected register.
// Define STM_R15_EN to honour reglist bit 15, which stores pc_val at the highest address of the block.
module stm_sequencer #(
    parameter int unsigned STEP = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [15:0]            reglist,
    input  logic [31:0]            base_addr,
    input  logic                   up,
    input  logic                   pre,
    input  logic [31:0]            pc_val,
    output logic [3:0]             ra,
    input  logic [31:0]            rd,
    stm_sequencer_if.master        mem,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            wb_addr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pending_q, pending_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wb_addr_q, wb_addr_d;

    logic [15:0] eff_list;
    logic [4:0]  cnt;
    logic [31:0] step_w;
    logic [31:0] span;
    logic [3:0]  low_idx;
    logic        found;

`ifdef STM_R15_EN
    assign eff_list = reglist;
`else
    logic unused_r15;
    assign eff_list   = {1'b0, reglist[14:0]};
    assign unused_r15 = ^{pc_val, reglist[15]};
`endif

    assign step_w = 32'(STEP);

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            cnt = cnt + {4'b0000, eff_list[i]};
        end
        span = step_w * {27'd0, cnt};
    end

    always_comb begin
        low_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (pending_q[i] && !found) begin
                low_idx = 4'(i);
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        addr_d       = addr_q;
        wb_addr_d    = wb_addr_q;
        ra           = '0;
        mem.mem_we   = 1'b0;
        mem.mem_wd   = '0;
        mem.mem_addr = addr_q;
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_DONE);
        wb_addr      = wb_addr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pending_d = eff_list;
                    wb_addr_d = up ? (base_addr + span) : (base_addr - span);
                    // Descending modes start low so the lowest register still lands at the lowest address.
                    case ({up, pre})
                        2'b10:   addr_d = base_addr;
                        2'b11:   addr_d = base_addr + step_w;
                        2'b00:   addr_d = base_addr - span + step_w;
                        default: addr_d = base_addr - span;
                    endcase
                    state_d = (eff_list != '0) ? S_WRITE : S_DONE;
                end
            end
            S_WRITE: begin
                ra         = low_idx;
                mem.mem_we = 1'b1;
`ifdef STM_R15_EN
                mem.mem_wd = (low_idx == 4'd15) ? pc_val : rd;
`else
                mem.mem_wd = rd;
`endif
                if (mem.mem_ready) begin
                    pending_d = pending_q & ~(16'd1 << low_idx);
                    addr_d    = addr_q + step_w;
                    if (pending_d == '0) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            addr_q    <= '0;
            wb_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            addr_q    <= addr_d;
            wb_addr_q <= wb_addr_d;
        end
    end

endmodule
